// File: rtl/fetch_redirect_unit_pkg.sv
// Shared core package: fetch FSM encoding, fetch defaults and the RV32I
// opcode/funct3 constants that the EX-stage branch and jump logic decodes.
package fetch_redirect_unit_pkg;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int unsigned INCR_DEFAULT     = 4;

   localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
   localparam logic [6:0] OPC_JAL      = 7'b110_1111;
   localparam logic [6:0] OPC_JALR     = 7'b110_0111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_redirect_unit_pc_reg.sv
// 32-bit program counter register with asynchronous reset and write enable.
module pc_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_we,
   input  logic [31:0] i_d,
   output logic [31:0] o_q
);

   logic [31:0] r_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (i_we) begin
         r_pc <= i_d;
      end
   end

   assign o_q = r_pc;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC sequencer: resolves EX redirects, load-use stalls and halts,
// and squashes the two younger pipeline registers on a taken redirect.
module fetch_redirect_unit
   import fetch_redirect_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned INCR     = INCR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Decision,
   input  logic        Jump,
   input  logic [31:0] target,
   input  logic        stall,
   input  logic        halt_req,
   output logic [31:0] pc,
   output logic        pc_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        halted,
   output logic        misalign_err,
   output logic [15:0] redirect_count
);

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic        r_misalign;
   logic [15:0] r_count;
   logic [31:0] w_pc;
   logic [31:0] w_pc_next;
   logic        w_pc_we;
   logic        w_flush;
   logic        w_set_misalign;
   logic        w_count_inc;
   logic        w_redirect;
   logic        w_target_misaligned;

   assign w_redirect          = Decision | Jump;
   assign w_target_misaligned = |target[1:0];

   always_comb begin
      w_state_next   = r_state;
      w_pc_we        = 1'b0;
      w_pc_next      = w_pc + 32'(INCR);
      w_flush        = 1'b0;
      w_set_misalign = 1'b0;
      w_count_inc    = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (halt_req) begin
               w_state_next = ST_HALT;
            end else if (w_redirect && w_target_misaligned) begin
               w_set_misalign = 1'b1;
               w_state_next   = ST_HALT;
            end else if (w_redirect) begin
               w_pc_we      = 1'b1;
               w_pc_next    = target;
               w_flush      = 1'b1;
               w_count_inc  = 1'b1;
               w_state_next = ST_FLUSH;
            end else if (!stall) begin
               w_pc_we = 1'b1;
            end
         end
         // Redirects arriving here belong to already-squashed instructions.
         ST_FLUSH: begin
            if (halt_req) begin
               w_state_next = ST_HALT;
            end else begin
               w_state_next = ST_RUN;
               w_pc_we      = ~stall;
            end
         end
         ST_HALT: begin
            w_state_next = ST_HALT;
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_misalign <= 1'b0;
         r_count    <= 16'h0000;
      end else begin
         r_state <= w_state_next;
         if (w_set_misalign) begin
            r_misalign <= 1'b1;
         end
         if (w_count_inc) begin
            r_count <= sat_inc16(r_count);
         end
      end
   end

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk  (clk),
      .rst  (rst),
      .i_we (w_pc_we),
      .i_d  (w_pc_next),
      .o_q  (w_pc)
   );

   // Combinational strobes are masked so nothing leaks out while reset is held.
   assign pc             = w_pc;
   assign pc_write       = w_pc_we & ~rst;
   assign if_id_flush    = w_flush & ~rst;
   assign id_ex_flush    = w_flush & ~rst;
   assign halted         = (r_state == ST_HALT);
   assign misalign_err   = r_misalign;
   assign redirect_count = r_count;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed and randomized check of fetch_redirect_unit against a cycle-level
// behavioural model of the fetch rules.
module tb_fetch_redirect_unit;

   logic        clk;
   logic        rst;
   logic        Decision;
   logic        Jump;
   logic [31:0] target;
   logic        stall;
   logic        halt_req;
   logic [31:0] pc;
   logic        pc_write;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        halted;
   logic        misalign_err;
   logic [15:0] redirect_count;

   int n_err;
   int n_checks;

   // model state
   logic [31:0] m_pc;
   bit          m_after_redirect;
   bit          m_halted;
   bit          m_mis;
   logic [15:0] m_cnt;

   fetch_redirect_unit dut (
      .clk            (clk),
      .rst            (rst),
      .Decision       (Decision),
      .Jump           (Jump),
      .target         (target),
      .stall          (stall),
      .halt_req       (halt_req),
      .pc             (pc),
      .pc_write       (pc_write),
      .if_id_flush    (if_id_flush),
      .id_ex_flush    (id_ex_flush),
      .halted         (halted),
      .misalign_err   (misalign_err),
      .redirect_count (redirect_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input bit e_we, input bit e_fl);
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".pc_write"}, 32'(pc_write), 32'(e_we));
      chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e_fl));
      chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(e_fl));
      chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
      chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(m_mis));
      chk({tag, ".redirect_count"}, 32'(redirect_count), 32'(m_cnt));
   endtask

   // Called at a falling edge; applies inputs, checks, advances one cycle.
   task automatic step(input string tag, input logic d, input logic j,
                       input logic [31:0] t, input logic s, input logic h);
      bit          e_we;
      bit          e_fl;
      bit          take;
      logic [31:0] n_pc;
      bit          n_after;
      bit          n_halted;
      Decision = d;
      Jump     = j;
      target   = t;
      stall    = s;
      halt_req = h;
      #1;
      e_we     = 0;
      e_fl     = 0;
      n_pc     = m_pc;
      n_after  = 0;
      n_halted = m_halted;
      take     = !m_halted && !m_after_redirect && (d || j);
      if (m_halted) begin
         n_halted = 1;
      end else if (h) begin
         n_halted = 1;
      end else if (take && (t % 4 != 0)) begin
         m_mis    = 1;
         n_halted = 1;
      end else if (take) begin
         e_we    = 1;
         e_fl    = 1;
         n_pc    = t;
         n_after = 1;
      end else if (!s) begin
         e_we = 1;
         n_pc = m_pc + 32'd4;
      end
      // misalign flag is sticky from the edge, so compare with the pre-edge value
      begin
         bit keep_mis;
         keep_mis = m_mis;
         if (take && (t % 4 != 0) && !h) m_mis = 0;
         check_all(tag, e_we, e_fl);
         m_mis = keep_mis;
      end
      @(posedge clk);
      if (e_fl && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_pc             = n_pc;
      m_after_redirect = n_after;
      m_halted         = n_halted;
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst      = 1'b1;
      Decision = 1'b1;
      Jump     = 1'b1;
      target   = 32'h0000_0100;
      stall    = 1'b0;
      halt_req = 1'b0;
      m_pc             = 32'h0000_0000;
      m_after_redirect = 0;
      m_halted         = 0;
      m_mis            = 0;
      m_cnt            = 16'h0000;
      #1;
      check_all(tag, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_err    = 0;
      n_checks = 0;
      rst      = 1'b1;
      Decision = 1'b0;
      Jump     = 1'b0;
      target   = 32'h0;
      stall    = 1'b0;
      halt_req = 1'b0;
      @(negedge clk);
      do_reset("reset0");

      // sequential fetch from reset
      for (int i = 0; i < 4; i++) step("seq", 0, 0, 32'h0, 0, 0);
      step("branch", 1, 0, 32'h0000_0040, 0, 0);
      step("flush_ignores", 1, 0, 32'h0000_0040, 0, 0);
      chk("pc_after_flush", pc, 32'h0000_0044);
      step("jump_stall", 0, 1, 32'h0000_0080, 1, 0);
      chk("pc_after_jump", pc, 32'h0000_0080);
      step("post_jump", 0, 0, 32'h0, 0, 0);
      step("misalign", 0, 1, 32'h0000_0102, 0, 0);
      chk("misalign_flag", 32'(misalign_err), 32'd1);
      for (int i = 0; i < 3; i++) step("mis_halt", 1, 1, 32'h0000_0200, 0, 0);

      // reset while halted, then halt with a concurrent branch
      do_reset("reset_halt");
      step("run1", 0, 0, 32'h0, 0, 0);
      step("halt_req", 1, 0, 32'h0000_0200, 0, 1);
      for (int i = 0; i < 10; i++)
         step("halt_frozen", 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC,
              1'($urandom), 1'($urandom));
      do_reset("reset_after_halt");
      step("first_fetch", 0, 0, 32'h0, 0, 0);

      // wrap-around
      step("to_top", 0, 1, 32'hFFFF_FFFC, 0, 0);
      step("wrap", 0, 0, 32'h0, 0, 0);
      chk("pc_wrapped", pc, 32'h0000_0000);
      step("after_wrap", 0, 0, 32'h0, 0, 0);

      // reset during the flush cycle
      step("redir_before_rst", 1, 0, 32'h0000_0300, 0, 0);
      do_reset("reset_mid_flush");

      for (int i = 0; i < 500; i++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
         if (m_halted && $urandom_range(0, 3) == 0) do_reset("rand_reset");
         step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t,
              $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0);
      end

      // saturation: preload the counter near its ceiling, then keep redirecting
      do_reset("reset_sat");
      force dut.r_count = 16'hFFF0;
      #1;
      release dut.r_count;
      m_cnt = 16'hFFF0;
      for (int i = 0; i < 20; i++) begin
         step("sat_redirect", 0, 1, 32'h0000_1000 + 32'(i * 16), 0, 0);
         step("sat_flush", 0, 0, 32'h0, 0, 0);
      end
      chk("count_saturated", 32'(redirect_count), 32'h0000_FFFF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
